// File: rtl/dma_ram_pkg.sv
// Shared types and helpers for the RAM-to-stream read DMA: FSM state encoding,
// row-size arithmetic and the final-beat byte-keep mask.
package dma_ram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Widest row (all segments side by side, in bytes) the keep helper can describe.
  localparam int unsigned KEEP_MAX = 512;

  function automatic int unsigned row_bytes(input int unsigned seg_count,
                                            input int unsigned seg_be_width);
    return seg_count * seg_be_width;
  endfunction

  // Keep mask for the last beat: low `rem` bytes, or the whole row when rem is zero.
  function automatic logic [KEEP_MAX-1:0] final_keep(input int unsigned rem,
                                                     input int unsigned nbytes);
    int unsigned n;
    logic [KEEP_MAX-1:0] k;
    n = (rem == 0) ? nbytes : rem;
    k = '0;
    for (int unsigned i = 0; i < KEEP_MAX; i++) k[i] = (i < n);
    return k;
  endfunction

endpackage

// File: rtl/dma_ram_rd_stream_if.sv
// Bus bundle for dma_ram_rd_stream: command input, segmented RAM read port and
// AXI-Stream output. The slave modport is the DMA engine's view; master is its environment.
interface dma_ram_rd_stream_if #(
  parameter int SIZE           = 4096,
  parameter int SEG_COUNT      = 2,
  parameter int SEG_DATA_WIDTH = 128,
  parameter int SEG_BE_WIDTH   = SEG_DATA_WIDTH / 8,
  parameter int SEG_ADDR_WIDTH = $clog2(SIZE / (SEG_COUNT * SEG_BE_WIDTH)),
  parameter int LEN_WIDTH      = 16,
  parameter int TAG_WIDTH      = 8,
  parameter int RAM_ADDR_WIDTH = SEG_ADDR_WIDTH + $clog2(SEG_COUNT * SEG_BE_WIDTH)
);

  logic [RAM_ADDR_WIDTH-1:0]             s_cmd_addr;
  logic [LEN_WIDTH-1:0]                  s_cmd_len;
  logic [TAG_WIDTH-1:0]                  s_cmd_tag;
  logic                                  s_cmd_valid;
  logic                                  s_cmd_ready;

  logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0]   ram_rd_cmd_addr;
  logic [SEG_COUNT-1:0]                  ram_rd_cmd_valid;
  logic [SEG_COUNT-1:0]                  ram_rd_cmd_ready;
  logic [SEG_COUNT*SEG_DATA_WIDTH-1:0]   ram_rd_resp_data;
  logic [SEG_COUNT-1:0]                  ram_rd_resp_valid;
  logic [SEG_COUNT-1:0]                  ram_rd_resp_ready;

  logic [SEG_COUNT*SEG_DATA_WIDTH-1:0]   m_axis_tdata;
  logic [SEG_COUNT*SEG_BE_WIDTH-1:0]     m_axis_tkeep;
  logic                                  m_axis_tvalid;
  logic                                  m_axis_tready;
  logic                                  m_axis_tlast;
  logic [TAG_WIDTH-1:0]                  m_axis_tid;

  modport slave (
    input  s_cmd_addr, s_cmd_len, s_cmd_tag, s_cmd_valid,
    output s_cmd_ready,
    output ram_rd_cmd_addr, ram_rd_cmd_valid,
    input  ram_rd_cmd_ready,
    input  ram_rd_resp_data, ram_rd_resp_valid,
    output ram_rd_resp_ready,
    output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tid,
    input  m_axis_tready
  );

  modport master (
    output s_cmd_addr, s_cmd_len, s_cmd_tag, s_cmd_valid,
    input  s_cmd_ready,
    input  ram_rd_cmd_addr, ram_rd_cmd_valid,
    output ram_rd_cmd_ready,
    output ram_rd_resp_data, ram_rd_resp_valid,
    input  ram_rd_resp_ready,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tid,
    output m_axis_tready
  );

endinterface

// File: rtl/dma_ram_rd_stream.sv
// Reads a byte range from a segmented RAM row by row and streams it out on AXI-Stream.
// Define DMA_RAM_RD_STREAM_STATUS_EN to add the done_valid/done_tag completion strobe.
module dma_ram_rd_stream
  import dma_ram_pkg::*;
#(
  parameter int SIZE            = 4096,
  parameter int SEG_COUNT       = 2,
  parameter int SEG_DATA_WIDTH  = 128,
  parameter int SEG_BE_WIDTH    = SEG_DATA_WIDTH / 8,
  parameter int SEG_ADDR_WIDTH  = $clog2(SIZE / (SEG_COUNT * SEG_BE_WIDTH)),
  parameter int LEN_WIDTH       = 16,
  parameter int TAG_WIDTH       = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dma_ram_rd_stream_if.slave   bus
`ifdef DMA_RAM_RD_STREAM_STATUS_EN
  ,
  output logic                 done_valid,
  output logic [TAG_WIDTH-1:0] done_tag
`endif
);

  localparam int unsigned ROW_BYTES = row_bytes(SEG_COUNT, SEG_BE_WIDTH);
  localparam int ROW_SHIFT = $clog2(ROW_BYTES);
  localparam int KEEP_W    = SEG_COUNT * SEG_BE_WIDTH;
  localparam int DATA_W    = SEG_COUNT * SEG_DATA_WIDTH;
  localparam int OUT_W     = $clog2(MAX_OUTSTANDING + 1);

  state_t                    state_q, state_d;
  logic [SEG_ADDR_WIDTH-1:0] row_q, row_d;
  logic [LEN_WIDTH-1:0]      issue_left_q, issue_left_d;
  logic [LEN_WIDTH-1:0]      beats_left_q, beats_left_d;
  logic [TAG_WIDTH-1:0]      tag_q, tag_d;
  logic [ROW_SHIFT-1:0]      rem_q, rem_d;
  logic [SEG_COUNT-1:0]      seg_done_q, seg_done_d;
  logic [OUT_W-1:0]          outst_q, outst_d;
  logic [DATA_W-1:0]         tdata_q, tdata_d;
  logic [KEEP_W-1:0]         tkeep_q, tkeep_d;
  logic                      tlast_q, tlast_d;
  logic                      tvalid_q, tvalid_d;
  logic [TAG_WIDTH-1:0]      tid_q, tid_d;

  logic [SEG_COUNT-1:0]      cmd_valid;
  logic [SEG_COUNT-1:0]      seg_hs;
  logic                      row_issue;
  logic                      resp_pop;
  logic                      beat_accept;
  logic                      is_last;

  // NOTE: every signal assigned here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    issue_left_d = issue_left_q;
    beats_left_d = beats_left_q;
    tag_d        = tag_q;
    rem_d        = rem_q;
    seg_done_d   = seg_done_q;
    outst_d      = outst_q;
    tdata_d      = tdata_q;
    tkeep_d      = tkeep_q;
    tlast_d      = tlast_q;
    tvalid_d     = tvalid_q;
    tid_d        = tid_q;
    cmd_valid    = '0;

    // Segments that already took the current row stay quiet until the others catch up.
    if (state_q == ISSUE && outst_q != OUT_W'(MAX_OUTSTANDING)) cmd_valid = ~seg_done_q;
    seg_hs      = cmd_valid & bus.ram_rd_cmd_ready;
    row_issue   = (state_q == ISSUE) && (&(seg_done_q | seg_hs));
    beat_accept = tvalid_q && bus.m_axis_tready;
    resp_pop    = (state_q != IDLE) && (&bus.ram_rd_resp_valid) &&
                  (!tvalid_q || bus.m_axis_tready);
    is_last     = (beats_left_q == LEN_WIDTH'(1));

    unique case (state_q)
      IDLE: begin
        if (bus.s_cmd_valid && bus.s_cmd_len != '0) begin
          row_d        = SEG_ADDR_WIDTH'(bus.s_cmd_addr >> ROW_SHIFT);
          issue_left_d = LEN_WIDTH'(bus.s_cmd_len >> ROW_SHIFT) +
                         LEN_WIDTH'(|bus.s_cmd_len[ROW_SHIFT-1:0]);
          beats_left_d = LEN_WIDTH'(bus.s_cmd_len >> ROW_SHIFT) +
                         LEN_WIDTH'(|bus.s_cmd_len[ROW_SHIFT-1:0]);
          rem_d        = bus.s_cmd_len[ROW_SHIFT-1:0];
          tag_d        = bus.s_cmd_tag;
          seg_done_d   = '0;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (row_issue) begin
          row_d        = row_q + SEG_ADDR_WIDTH'(1);
          issue_left_d = issue_left_q - LEN_WIDTH'(1);
          seg_done_d   = '0;
          if (issue_left_q == LEN_WIDTH'(1)) state_d = DRAIN;
        end else begin
          seg_done_d = seg_done_q | seg_hs;
        end
      end
      DRAIN: begin
        if (beat_accept && tlast_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (resp_pop) begin
      tdata_d      = bus.ram_rd_resp_data;
      tkeep_d      = is_last ? KEEP_W'(final_keep(32'(rem_q), ROW_BYTES)) : '1;
      tlast_d      = is_last;
      tid_d        = tag_q;
      tvalid_d     = 1'b1;
      beats_left_d = beats_left_q - LEN_WIDTH'(1);
    end else if (beat_accept) begin
      tvalid_d = 1'b0;
    end

    unique case ({row_issue, resp_pop})
      2'b10:   outst_d = outst_q + OUT_W'(1);
      2'b01:   outst_d = outst_q - OUT_W'(1);
      default: outst_d = outst_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, matching real hardware.
  // NOTE: the wide output data register is reset too: it is a single beat, not a
  // memory array, and the stream must read as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      row_q        <= '0;
      issue_left_q <= '0;
      beats_left_q <= '0;
      tag_q        <= '0;
      rem_q        <= '0;
      seg_done_q   <= '0;
      outst_q      <= '0;
      tdata_q      <= '0;
      tkeep_q      <= '0;
      tlast_q      <= 1'b0;
      tvalid_q     <= 1'b0;
      tid_q        <= '0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      issue_left_q <= issue_left_d;
      beats_left_q <= beats_left_d;
      tag_q        <= tag_d;
      rem_q        <= rem_d;
      seg_done_q   <= seg_done_d;
      outst_q      <= outst_d;
      tdata_q      <= tdata_d;
      tkeep_q      <= tkeep_d;
      tlast_q      <= tlast_d;
      tvalid_q     <= tvalid_d;
      tid_q        <= tid_d;
    end
  end

  assign bus.s_cmd_ready       = (state_q == IDLE);
  assign bus.ram_rd_cmd_addr   = {SEG_COUNT{row_q}};
  assign bus.ram_rd_cmd_valid  = cmd_valid;
  assign bus.ram_rd_resp_ready = {SEG_COUNT{resp_pop}};
  assign bus.m_axis_tdata      = tdata_q;
  assign bus.m_axis_tkeep      = tkeep_q;
  assign bus.m_axis_tvalid     = tvalid_q;
  assign bus.m_axis_tlast      = tlast_q;
  assign bus.m_axis_tid        = tid_q;

`ifdef DMA_RAM_RD_STREAM_STATUS_EN
  logic cmd_zero;
  // A zero-length command completes on acceptance; the tag comes straight from the command.
  assign cmd_zero   = (state_q == IDLE) && bus.s_cmd_valid && (bus.s_cmd_len == '0);
  assign done_valid = (beat_accept && tlast_q) || cmd_zero;
  assign done_tag   = (state_q == IDLE) ? bus.s_cmd_tag : tag_q;
`endif

endmodule

// File: tb/tb_dma_ram_rd_stream.sv
// Self-checking bench for dma_ram_rd_stream: randomized two-segment RAM model and
// stream sink, with a transaction-level model predicting rows, beats and keeps.
module tb_dma_ram_rd_stream;

  localparam int SEG_COUNT  = 2;
  localparam int SEG_DW     = 128;
  localparam int SEG_BE     = 16;
  localparam int SIZE       = 4096;
  localparam int SEG_AW     = 7;
  localparam int LEN_W      = 16;
  localparam int TAG_W      = 8;
  localparam int MAX_OUT    = 4;
  localparam int ROW_BYTES  = 32;
  localparam int NROWS      = SIZE / ROW_BYTES;

  typedef struct {
    logic [255:0] data;
    logic [31:0]  keep;
    logic         last;
    logic [7:0]   tid;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dma_ram_rd_stream_if #(.SIZE(SIZE), .SEG_COUNT(SEG_COUNT), .SEG_DATA_WIDTH(SEG_DW),
                         .LEN_WIDTH(LEN_W), .TAG_WIDTH(TAG_W)) bus ();

`ifdef DMA_RAM_RD_STREAM_STATUS_EN
  logic       done_valid;
  logic [7:0] done_tag;
`endif

  dma_ram_rd_stream #(.SIZE(SIZE), .SEG_COUNT(SEG_COUNT), .SEG_DATA_WIDTH(SEG_DW),
                      .LEN_WIDTH(LEN_W), .TAG_WIDTH(TAG_W), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef DMA_RAM_RD_STREAM_STATUS_EN
    ,
    .done_valid (done_valid),
    .done_tag   (done_tag)
`endif
  );

  logic [7:0]  mem [SIZE];
  beat_t       exp_q[$];
  int unsigned exp_rows0[$], exp_rows1[$];
  int unsigned pend0[$], pend1[$];
  int unsigned addr_log0[$];
  logic [31:0] keep_log[$];
  logic        last_log[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          hs0 = 0, hs1 = 0, pops = 0, pops_left = 0, beats_acc = 0, max_outst = 0;
  bit          stall_hold = 1'b0;
  bit          prev_stalled = 1'b0;
  beat_t       prev_beat;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] seg_data(input int unsigned row, input int unsigned seg);
    logic [127:0] d;
    for (int b = 0; b < SEG_BE; b++) d[b*8 +: 8] = mem[row*ROW_BYTES + seg*SEG_BE + b];
    return d;
  endfunction

  // RAM segments, stream sink and the per-cycle compare process.
  initial begin
    logic [1:0]   rv;
    logic [255:0] rd;
    int           outst;
    bus.ram_rd_cmd_ready  = '0;
    bus.ram_rd_resp_valid = '0;
    bus.ram_rd_resp_data  = '0;
    bus.m_axis_tready     = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.ram_rd_cmd_ready  = '0;
        bus.ram_rd_resp_valid = '0;
        bus.m_axis_tready     = 1'b0;
        continue;
      end
      bus.ram_rd_cmd_ready = {1'($urandom % 4 != 0), 1'($urandom % 4 != 0)};
      rv[0] = (pend0.size() > 0) && ($urandom % 4 != 0);
      rv[1] = (pend1.size() > 0) && ($urandom % 4 != 0);
      rd = '0;
      if (pend0.size() > 0) rd[127:0]   = seg_data(pend0[0], 0);
      if (pend1.size() > 0) rd[255:128] = seg_data(pend1[0], 1);
      bus.ram_rd_resp_valid = rv;
      bus.ram_rd_resp_data  = rd;
      bus.m_axis_tready     = stall_hold ? 1'b0 : 1'($urandom % 3 != 0);
      #1;
      if (!rst_n) continue;

      if (prev_stalled) begin
        check("stall_tvalid", bus.m_axis_tvalid, 1'b1);
        check("stall_tdata", bus.m_axis_tdata, prev_beat.data);
        check("stall_tkeep", bus.m_axis_tkeep, prev_beat.keep);
        check("stall_tlast", bus.m_axis_tlast, prev_beat.last);
      end

      outst = ((hs0 < hs1) ? hs0 : hs1) - pops;
      if (outst > max_outst) max_outst = outst;
      if (outst >= MAX_OUT) check("cmd_valid_throttled", bus.ram_rd_cmd_valid, 2'b00);

      if (bus.ram_rd_cmd_valid[0] && bus.ram_rd_cmd_ready[0]) begin
        if (exp_rows0.size() == 0) check("seg0_unexpected_read", 1, 0);
        else check("seg0_row_addr", bus.ram_rd_cmd_addr[SEG_AW-1:0], exp_rows0.pop_front());
        pend0.push_back(bus.ram_rd_cmd_addr[SEG_AW-1:0]);
        addr_log0.push_back(bus.ram_rd_cmd_addr[SEG_AW-1:0]);
        hs0++;
      end
      if (bus.ram_rd_cmd_valid[1] && bus.ram_rd_cmd_ready[1]) begin
        if (exp_rows1.size() == 0) check("seg1_unexpected_read", 1, 0);
        else check("seg1_row_addr", bus.ram_rd_cmd_addr[2*SEG_AW-1:SEG_AW], exp_rows1.pop_front());
        pend1.push_back(bus.ram_rd_cmd_addr[2*SEG_AW-1:SEG_AW]);
        hs1++;
      end

      if (pops_left > 0)
        check("resp_ready", bus.ram_rd_resp_ready,
              {2{(&rv) && (!bus.m_axis_tvalid || bus.m_axis_tready)}});
      if (&(rv & bus.ram_rd_resp_ready)) begin
        void'(pend0.pop_front());
        void'(pend1.pop_front());
        pops++;
        pops_left--;
      end

      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", bus.m_axis_tvalid, 1'b0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_tdata", bus.m_axis_tdata, e.data);
          check("beat_tkeep", bus.m_axis_tkeep, e.keep);
          check("beat_tlast", bus.m_axis_tlast, e.last);
          check("beat_tid", bus.m_axis_tid, e.tid);
        end
        keep_log.push_back(bus.m_axis_tkeep);
        last_log.push_back(bus.m_axis_tlast);
        beats_acc++;
      end

      prev_stalled   = bus.m_axis_tvalid && !bus.m_axis_tready;
      prev_beat.data = bus.m_axis_tdata;
      prev_beat.keep = bus.m_axis_tkeep;
      prev_beat.last = bus.m_axis_tlast;
    end
  end

  task automatic send_cmd(input int unsigned addr, input int unsigned len, input logic [7:0] tag);
    int unsigned rows, row0, rem, r;
    int guard;
    beat_t b;
    @(negedge clk);
    bus.s_cmd_addr  = addr[11:0];
    bus.s_cmd_len   = len[15:0];
    bus.s_cmd_tag   = tag;
    bus.s_cmd_valid = 1'b1;
    #1;
    guard = 0;
    while (!bus.s_cmd_ready && guard < 2000) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check("cmd_accepted", bus.s_cmd_ready, 1'b1);
    addr_log0.delete();
    keep_log.delete();
    last_log.delete();
    rows = (len + ROW_BYTES - 1) / ROW_BYTES;
    row0 = (addr % SIZE) / ROW_BYTES;
    rem  = len % ROW_BYTES;
    for (int unsigned i = 0; i < rows; i++) begin
      r = (row0 + i) % NROWS;
      exp_rows0.push_back(r);
      exp_rows1.push_back(r);
      b.data = {seg_data(r, 1), seg_data(r, 0)};
      b.last = (i == rows - 1);
      b.keep = (b.last && rem != 0) ? ((32'h1 << rem) - 32'h1) : 32'hFFFF_FFFF;
      b.tid  = tag;
      exp_q.push_back(b);
    end
    pops_left += rows;
`ifdef DMA_RAM_RD_STREAM_STATUS_EN
    if (len == 0) begin
      check("len0_done_valid", done_valid, 1'b1);
      check("len0_done_tag", done_tag, tag);
    end
`endif
    @(negedge clk);
    bus.s_cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int g = 0;
    while ((exp_q.size() != 0 || !bus.s_cmd_ready) && g < 5000) begin
      @(negedge clk);
      #2;
      g++;
    end
    check({name, "_beats_left"}, exp_q.size(), 0);
    check({name, "_idle"}, bus.s_cmd_ready, 1'b1);
  endtask

  initial begin
    int b0, h0, g;
    bus.s_cmd_valid = 1'b0;
    bus.s_cmd_addr  = '0;
    bus.s_cmd_len   = '0;
    bus.s_cmd_tag   = '0;
    for (int i = 0; i < SIZE; i++) mem[i] = 8'($urandom);

    repeat (3) @(negedge clk);
    #1;
    check("rst_tvalid", bus.m_axis_tvalid, 1'b0);
    check("rst_tdata", bus.m_axis_tdata, '0);
    check("rst_tkeep", bus.m_axis_tkeep, '0);
    check("rst_tlast", bus.m_axis_tlast, 1'b0);
    check("rst_tid", bus.m_axis_tid, '0);
    check("rst_cmd_valid", bus.ram_rd_cmd_valid, 2'b00);
    check("rst_resp_ready", bus.ram_rd_resp_ready, 2'b00);
    check("rst_cmd_ready", bus.s_cmd_ready, 1'b1);
    #2 rst_n = 1'b1;

    // Aligned 64 bytes: rows 2 and 3, two full beats.
    send_cmd(12'h040, 64, 8'h11);
    wait_done("a040");
    check("a040_row0", addr_log0[0], 2);
    check("a040_row1", addr_log0[1], 3);
    check("a040_nbeats", keep_log.size(), 2);
    check("a040_keep0", keep_log[0], 32'hFFFF_FFFF);
    check("a040_keep1", keep_log[1], 32'hFFFF_FFFF);
    check("a040_last0", last_log[0], 1'b0);
    check("a040_last1", last_log[1], 1'b1);

    // 40 bytes: partial final beat keeps the low 8 bytes.
    send_cmd(12'h000, 40, 8'h22);
    wait_done("a000");
    check("a000_nbeats", keep_log.size(), 2);
    check("a000_keep1", keep_log[1], 32'h0000_00FF);
    check("a000_last1", last_log[1], 1'b1);

    // Row address wraps from the top row back to row 0.
    send_cmd(12'hFE0, 64, 8'h33);
    wait_done("afe0");
    check("afe0_row0", addr_log0[0], 127);
    check("afe0_row1", addr_log0[1], 0);

    // Long transfer with a 20-cycle downstream stall in the middle.
    b0 = beats_acc;
    max_outst = 0;
    send_cmd(12'h400, 1024, 8'h44);
    g = 0;
    while (beats_acc - b0 < 10 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    stall_hold = 1'b1;
    repeat (20) @(negedge clk);
    stall_hold = 1'b0;
    wait_done("l1024");
    check("l1024_nbeats", beats_acc - b0, 32);
    check("l1024_max_outstanding_ok", max_outst <= MAX_OUT, 1'b1);

    // Zero length: no RAM read, no beat.
    b0 = beats_acc;
    h0 = hs0 + hs1;
    send_cmd(12'h080, 0, 8'h5A);
    repeat (5) @(negedge clk);
    check("len0_no_read", hs0 + hs1 - h0, 0);
    check("len0_no_beat", beats_acc - b0, 0);
    check("len0_idle", bus.s_cmd_ready, 1'b1);

    // Reset while the third of eight beats is on the stream.
    b0 = beats_acc;
    send_cmd(12'h300, 256, 8'h66);
    g = 0;
    do begin
      @(negedge clk);
      #2;
      g++;
    end while (!(beats_acc - b0 >= 2 && bus.m_axis_tvalid) && g < 2000);
    rst_n = 1'b0;
    #1;
    check("midrst_tvalid", bus.m_axis_tvalid, 1'b0);
    check("midrst_tdata", bus.m_axis_tdata, '0);
    check("midrst_tkeep", bus.m_axis_tkeep, '0);
    check("midrst_tlast", bus.m_axis_tlast, 1'b0);
    check("midrst_tid", bus.m_axis_tid, '0);
    check("midrst_cmd_valid", bus.ram_rd_cmd_valid, 2'b00);
    check("midrst_resp_ready", bus.ram_rd_resp_ready, 2'b00);
    check("midrst_cmd_ready", bus.s_cmd_ready, 1'b1);
    exp_q.delete();
    exp_rows0.delete();
    exp_rows1.delete();
    pend0.delete();
    pend1.delete();
    hs0 = 0;
    hs1 = 0;
    pops = 0;
    pops_left = 0;
    prev_stalled = 1'b0;
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;

    send_cmd(12'h123, 100, 8'h77);
    wait_done("postrst");
    check("postrst_row0", addr_log0[0], 9);
    check("postrst_nbeats", keep_log.size(), 4);
    check("postrst_keep3", keep_log[3], 32'h0000_000F);

    for (int i = 0; i < 25; i++) begin
      int unsigned len;
      len = ($urandom % 8 == 0) ? 0 : $urandom_range(1, 400);
      send_cmd($urandom % SIZE, len, 8'($urandom));
      wait_done("rand");
    end

    check("end_no_pending_reads", exp_rows0.size() + exp_rows1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dma_ram_rd_stream.md
DMA_RAM_RD_STREAM -- requirements
Module: dma_ram_rd_stream

Interface
REQ-001 SHALL have parameter SIZE, default 4096, meaning RAM size in bytes.
REQ-002 SHALL have parameter SEG_COUNT, default 2, meaning RAM segment count.
REQ-003 SHALL have parameter SEG_DATA_WIDTH, default 128, meaning segment data width.
REQ-004 SHALL have parameter SEG_BE_WIDTH, default SEG_DATA_WIDTH/8, meaning segment byte lanes.
REQ-005 SHALL have parameter SEG_ADDR_WIDTH, default $clog2(SIZE/(SEG_COUNT*SEG_BE_WIDTH)), meaning segment row address width.
REQ-006 SHALL have parameter LEN_WIDTH, default 16, meaning command byte-length width.
REQ-007 SHALL have parameter TAG_WIDTH, default 8, meaning command tag width.
REQ-008 SHALL have parameter MAX_OUTSTANDING, default 4, meaning maximum issued-but-unreturned rows.
REQ-009 SHALL have ports: clk in 1, clock; rst_n in 1, reset. One clock; reset is asynchronous and active-low.
REQ-010 SHALL have s_cmd_addr in RAM_ADDR_WIDTH (SEG_ADDR_WIDTH+$clog2(SEG_COUNT*SEG_BE_WIDTH)), byte address; s_cmd_len in LEN_WIDTH, byte count; s_cmd_tag in TAG_WIDTH; s_cmd_valid in 1; s_cmd_ready out 1.
REQ-011 SHALL have ram_rd_cmd_addr out SEG_COUNT*SEG_ADDR_WIDTH; ram_rd_cmd_valid out SEG_COUNT; ram_rd_cmd_ready in SEG_COUNT; ram_rd_resp_data in SEG_COUNT*SEG_DATA_WIDTH; ram_rd_resp_valid in SEG_COUNT; ram_rd_resp_ready out SEG_COUNT.
REQ-012 SHALL have m_axis_tdata out SEG_COUNT*SEG_DATA_WIDTH; m_axis_tkeep out SEG_COUNT*SEG_BE_WIDTH; m_axis_tvalid out 1; m_axis_tready in 1; m_axis_tlast out 1; m_axis_tid out TAG_WIDTH.

Function
REQ-013 SHALL implement states IDLE, ISSUE, DRAIN; s_cmd_ready=1 only in IDLE.
REQ-014 SHALL on command accept with len>0 latch row=addr>>$clog2(SEG_COUNT*SEG_BE_WIDTH), rows=ceil(len/row_bytes), tag, and enter ISSUE; low address bits ignored.
REQ-015 SHALL on command accept with len=0 issue no reads, emit no beat, and remain IDLE.
REQ-016 SHALL in ISSUE drive the same row address on all segments, asserting ram_rd_cmd_valid[n] until segment n handshakes; row advances only once every segment has handshaked for it (per-segment done bits).
REQ-017 SHALL deassert all ram_rd_cmd_valid while outstanding row count equals MAX_OUTSTANDING.
REQ-018 SHALL wrap row address modulo 2**SEG_ADDR_WIDTH.
REQ-019 SHALL move ISSUE->DRAIN after last row issued, DRAIN->IDLE when last beat accepted on m_axis.
REQ-020 SHALL assert ram_rd_resp_ready on all segments together iff all ram_rd_resp_valid are high and output register is empty or m_axis_tready=1.
REQ-021 SHALL register output: one beat per response row, concatenated segment data, segment 0 in LSBs.
REQ-022 SHALL set tkeep all ones except final beat, which keeps low (len mod row_bytes) bytes (all ones if remainder zero); tlast on final beat only; tid=tag.
REQ-023 SHALL hold m_axis signals stable while tvalid=1 and tready=0.
REQ-024 SHALL decrement outstanding count on response pop and increment on row issue; simultaneous events leave it unchanged.

Reset
REQ-025 SHALL on rst_n=0 asynchronously clear state to IDLE, counters to 0, m_axis_tvalid, ram_rd_cmd_valid, ram_rd_resp_ready to 0; data/tid/tkeep/tlast to 0.
REQ-026 SHALL on reset mid-transfer abandon the transfer; RAM-side in-flight responses are the RAM's responsibility (shared reset).

Configuration
REQ-027 SHALL with DMA_RAM_RD_STREAM_STATUS_EN defined add outputs done_valid (1) and done_tag (TAG_WIDTH), pulsing one cycle on final-beat acceptance or len=0 accept; without it those ports and logic are absent.

Structure
REQ-028 SHALL place state encoding enum and row-byte/keep helper constants in shared package dma_ram_pkg.
REQ-029 SHALL be a single module with no sub-modules; output register inline.

Verification (SEG_COUNT=2, SEG_DATA_WIDTH=128, SIZE=4096, row 32 bytes)
REQ-030 addr 0x040 len 64 -> ram_rd_cmd_addr rows 2,3; two beats tkeep 0xFFFFFFFF, tlast on second.
REQ-031 addr 0x000 len 40 -> two beats; second tkeep 0x000000FF, tlast=1.
REQ-032 addr 0xFE0 len 64 -> rows 127 then 0; data matches RAM contents.
REQ-033 len 1024, m_axis_tready low 20 cycles mid-transfer -> outstanding never exceeds 4, 32 beats in order, no loss or duplicate.
REQ-034 len 0 tag 0x5A -> no RAM read, no beat; with status macro done_valid pulse, done_tag=0x5A.
REQ-035 rst_n low during beat 3 of 8 -> all outputs 0 same cycle; next command completes correctly.
